// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite word-organised SRAM slave with byte lanes, wait states and ERROR response
package ahb_sram_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [1:0] HSIZE_8       = 2'b00;
    localparam logic [1:0] HSIZE_16      = 2'b01;
    localparam logic [1:0] HSIZE_32      = 2'b10;
    localparam logic [1:0] HSIZE_RSVD    = 2'b11;
    localparam logic       RESP_OKAY     = 1'b0;
    localparam logic       RESP_ERROR    = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [1:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [1:0]  trans;
        logic        mastlock;
        logic        ready;
        logic [31:0] wdata;
    } bus_slv_in;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
        logic        resp;
    } bus_slv_out;
endpackage

module ahb_sram_slave
    import ahb_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  bus_slv_in  in,
    output bus_slv_out out
);
    localparam int          ADDR_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS) * 32'd4;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE_S, WAIT_S, ERR1_S, ERR2_S} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              d_valid, d_valid_nx;
    logic              d_write, d_write_nx;
    logic [1:0]        d_size, d_size_nx;
    logic [1:0]        d_lane, d_lane_nx;
    logic [ADDR_W-1:0] d_idx, d_idx_nx;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] off;
    logic        bad;
    logic        accept;
    logic        commit;
    logic        ready;
    logic        resp;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        unused_ok;

    assign unused_ok = ^{in.burst, in.prot, in.mastlock};

    // addresses below BASE_ADDR wrap to a huge offset and fail the range check
    assign off = in.addr - BASE_ADDR;
    assign bad = (off >= SPAN)
              || (in.size == HSIZE_RSVD)
              || (in.size == HSIZE_16 && in.addr[0])
              || (in.size == HSIZE_32 && in.addr[1:0] != 2'b00);

    assign accept = sel && in.ready && ready
                 && (in.trans == HTRANS_NONSEQ || in.trans == HTRANS_SEQ);

    always_comb begin
        ready = 1'b1;
        resp  = RESP_OKAY;
        rdata = '0;
        case (state)
            IDLE_S: if (d_valid) rdata = mem[d_idx];
            WAIT_S: begin
                ready = (cnt == 4'd0);
                rdata = mem[d_idx];
            end
            ERR1_S: begin
                ready = 1'b0;
                resp  = RESP_ERROR;
            end
            ERR2_S: resp = RESP_ERROR;
            default: ;
        endcase
    end

    assign out = '{rdata: rdata, ready: ready, resp: resp};

    // any cycle with ready=1 ends the current data phase and may accept the next address phase
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        d_valid_nx = d_valid;
        d_write_nx = d_write;
        d_size_nx  = d_size;
        d_lane_nx  = d_lane;
        d_idx_nx   = d_idx;
        if (ready) begin
            state_nx   = IDLE_S;
            d_valid_nx = 1'b0;
            if (accept) begin
                d_write_nx = in.write;
                d_size_nx  = in.size;
                d_lane_nx  = in.addr[1:0];
                d_idx_nx   = off[ADDR_W+1:2];
                if (bad) begin
                    state_nx = ERR1_S;
                end else begin
                    d_valid_nx = 1'b1;
                    if (WAIT_STATES != 0) begin
                        state_nx = WAIT_S;
                        cnt_nx   = WAIT_LOAD;
                    end
                end
            end
        end else begin
            if (state == ERR1_S) state_nx = ERR2_S;
            if (state == WAIT_S) cnt_nx = cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE_S;
            cnt     <= 4'd0;
            d_valid <= 1'b0;
            d_write <= 1'b0;
            d_size  <= 2'b00;
            d_lane  <= 2'b00;
            d_idx   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            d_valid <= d_valid_nx;
            d_write <= d_write_nx;
            d_size  <= d_size_nx;
            d_lane  <= d_lane_nx;
            d_idx   <= d_idx_nx;
        end
    end

    always_comb begin
        be = 4'b0000;
        case (d_size)
            HSIZE_8:  be[d_lane] = 1'b1;
            HSIZE_16: be = d_lane[1] ? 4'b1100 : 4'b0011;
            default:  be = 4'b1111;
        endcase
    end

    // d_valid is cleared by reset, so a write interrupted by reset never lands
    assign commit = d_valid && d_write && ready;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[d_idx][8*i +: 8] <= in.wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed and randomized bench for ahb_sram_slave with a behavioural memory model
module tb_ahb_sram_slave;
    import ahb_sram_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;

    typedef struct {
        bit          sel;
        bit          write;
        logic [1:0]  size;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sel_v;
    logic       hready;
    bus_slv_in  drv;
    bus_slv_in  bin;
    bus_slv_out o0, o1, o2;

    xfer_t       q[$];
    logic [31:0] mdl [3][DEPTH];
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    logic [31:0] last_rdata;
    int          last_stall;

    always #5 clk = ~clk;

    assign hready = o0.ready & o1.ready & o2.ready;
    always_comb begin
        bin       = drv;
        bin.ready = hready;
    end

    ahb_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .sel(sel_v[0]), .in(bin), .out(o0));
    ahb_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u1 (
        .clk(clk), .rst(rst), .sel(sel_v[1]), .in(bin), .out(o1));
    ahb_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u2 (
        .clk(clk), .rst(rst), .sel(sel_v[2]), .in(bin), .out(o2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bus_slv_out get_out(input int d);
        return (d == 0) ? o0 : (d == 1) ? o1 : o2;
    endfunction

    function automatic int ws(input int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 2;
    endfunction

    function automatic bit is_err(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] o;
        o = a - BASE;
        return (o >= 32'(DEPTH * 4)) || (sz == 2'd3)
            || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    task automatic model_write(input int d, input xfer_t x);
        logic [31:0] o;
        int nb, lane0, w;
        o     = x.addr - BASE;
        nb    = 1 << x.size;
        lane0 = int'(o % 4);
        w     = int'(o / 4);
        for (int b = 0; b < nb; b++)
            mdl[d][w][8*(lane0+b) +: 8] = x.wdata[8*(lane0+b) +: 8];
    endtask

    task automatic add(input bit w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        xfer_t x;
        x.sel = 1'b1; x.write = w; x.size = sz; x.trans = HTRANS_NONSEQ; x.addr = a; x.wdata = wd;
        q.push_back(x);
    endtask

    task automatic add_raw(input bit s, input logic [1:0] tr, input bit w, input logic [31:0] a, input logic [31:0] wd);
        xfer_t x;
        x.sel = s; x.write = w; x.size = HSIZE_32; x.trans = tr; x.addr = a; x.wdata = wd;
        q.push_back(x);
    endtask

    // drives the queued transfers back to back on slave d, checking every data-phase cycle
    task automatic run(input int d);
        xfer_t      prev;
        bit         have_prev, acc, err;
        int         n_exp, cyc, idx;
        bus_slv_out o;
        logic [31:0] poff;
        have_prev = 1'b0;
        acc = 1'b0; err = 1'b0; n_exp = 1; idx = 0;
        for (int k = 0; k <= q.size(); k++) begin
            if (k < q.size()) begin
                sel_v      = q[k].sel ? 3'(1 << d) : 3'b000;
                drv.trans  = q[k].trans;
                drv.addr   = q[k].addr;
                drv.write  = q[k].write;
                drv.size   = q[k].size;
            end else begin
                sel_v     = 3'b000;
                drv.trans = HTRANS_IDLE;
            end
            drv.burst    = 3'($urandom);
            drv.prot     = 4'($urandom);
            drv.mastlock = 1'($urandom);
            if (have_prev) begin
                acc   = prev.sel && (prev.trans == HTRANS_NONSEQ || prev.trans == HTRANS_SEQ);
                err   = acc && is_err(prev.addr, prev.size);
                n_exp = !acc ? 1 : err ? 2 : ws(d) + 1;
                poff  = prev.addr - BASE;
                idx   = int'(poff / 4);
            end
            cyc = 0;
            drv.wdata = (have_prev && n_exp == 1) ? prev.wdata : $urandom;
            forever begin
                @(negedge clk);
                o = get_out(d);
                if (have_prev) begin
                    chk("ready", 32'(o.ready), 32'(cyc == n_exp - 1));
                    chk("resp", 32'(o.resp), 32'(err));
                    if (!acc || err) chk("rdata_zero", o.rdata, 32'd0);
                    else if (!prev.write && o.ready) begin
                        chk("rdata", o.rdata, mdl[d][idx]);
                        last_rdata = o.rdata;
                    end
                end
                @(posedge clk); #1;
                if (o.ready === 1'b1) break;
                cyc++;
                if (cyc > 32) begin
                    chk("stall_bound", 32'(cyc), 32'(n_exp - 1));
                    break;
                end
                drv.wdata = (have_prev && cyc == n_exp - 1) ? prev.wdata : $urandom;
            end
            last_stall = cyc;
            if (have_prev && acc && !err && prev.write) model_write(d, prev);
            if (k < q.size()) begin
                prev      = q[k];
                have_prev = 1'b1;
            end
        end
        q.delete();
    endtask

    initial begin
        bus_slv_out  o;
        logic [31:0] w0, old30;
        rst       = 1'b0;
        sel_v     = 3'b000;
        drv       = '0;
        drv.ready = 1'b1;
        drv.trans = HTRANS_IDLE;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            o = get_out(d);
            chk("reset_ready", 32'(o.ready), 32'd1);
            chk("reset_resp", 32'(o.resp), 32'(RESP_OKAY));
            chk("reset_rdata", o.rdata, 32'd0);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < DEPTH; w++) add(1'b1, HSIZE_32, BASE + 32'(4 * w), $urandom);
            run(d);
        end

        add(1'b1, HSIZE_32, BASE + 32'h10, 32'hDEAD_BEEF);
        add(1'b0, HSIZE_32, BASE + 32'h10, 32'd0);
        run(0);
        chk("t1_raw_rdata", last_rdata, 32'hDEAD_BEEF);

        add(1'b1, HSIZE_32, BASE + 32'h20, 32'h1122_3344);
        add(1'b1, HSIZE_8,  BASE + 32'h22, 32'h00AA_0000);
        add(1'b0, HSIZE_32, BASE + 32'h20, 32'd0);
        run(0);
        chk("t2_byte_lane", last_rdata, 32'h11AA_3344);

        add(1'b1, HSIZE_32, BASE + 32'h40, 32'h5A5A_0F0F);
        add(1'b0, HSIZE_32, BASE + 32'h40, 32'd0);
        run(1);
        chk("t3_wait_rdata", last_rdata, 32'h5A5A_0F0F);
        chk("t3_stall_cycles", 32'(last_stall), 32'd3);

        w0 = mdl[0][0];
        add(1'b1, HSIZE_32, BASE + 32'(DEPTH * 4), $urandom);
        add(1'b0, HSIZE_32, BASE, 32'd0);
        add(1'b1, HSIZE_32, BASE + 32'h02, $urandom);
        add(1'b1, HSIZE_16, BASE + 32'h01, $urandom);
        add(1'b1, HSIZE_32, BASE - 32'd4, $urandom);
        add(1'b1, HSIZE_RSVD, BASE, $urandom);
        add(1'b0, HSIZE_32, BASE, 32'd0);
        run(0);
        chk("t4_word0_kept", last_rdata, w0);

        add_raw(1'b1, HTRANS_IDLE,   1'b1, BASE, 32'h1234_5678);
        add_raw(1'b0, HTRANS_NONSEQ, 1'b1, BASE, 32'h8765_4321);
        add_raw(1'b1, HTRANS_BUSY,   1'b1, BASE, 32'hFFFF_FFFF);
        add(1'b0, HSIZE_32, BASE, 32'd0);
        run(0);
        chk("t5_no_write", last_rdata, w0);

        for (int d = 0; d < 3; d++) begin
            repeat (40) begin
                xfer_t x;
                x.sel   = ($urandom_range(0, 7) != 0);
                x.trans = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : HTRANS_NONSEQ;
                x.write = 1'($urandom);
                x.size  = ($urandom_range(0, 7) == 0) ? HSIZE_RSVD : 2'($urandom_range(0, 2));
                x.addr  = BASE - 32'd8 + 32'($urandom_range(0, DEPTH * 4 + 16));
                x.wdata = $urandom;
                q.push_back(x);
            end
            run(d);
        end

        old30     = mdl[2][12];
        sel_v     = 3'b100;
        drv.trans = HTRANS_NONSEQ;
        drv.write = 1'b1;
        drv.size  = HSIZE_32;
        drv.addr  = BASE + 32'h30;
        @(posedge clk); #1;
        sel_v     = 3'b000;
        drv.trans = HTRANS_IDLE;
        drv.wdata = ~old30;
        @(negedge clk);
        chk("t6_stalled", 32'(o2.ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("t6_reset_ready", 32'(o2.ready), 32'd1);
        chk("t6_reset_resp", 32'(o2.resp), 32'(RESP_OKAY));
        chk("t6_reset_rdata", o2.rdata, 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        add(1'b0, HSIZE_32, BASE + 32'h30, 32'd0);
        run(2);
        chk("t6_old_word", last_rdata, old30);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
